// File: rtl/bist_stream_engine.sv
// bist_stream_engine
//   Built-in self-test stream engine. Drives per-lane Galois LFSR stimulus (or a
//   held constant seed) into a DUT over a ready/valid handshake. Compacts DUT
//   responses into a per-lane MISR. Drains outstanding responses with an idle
//   timeout, then compares the signature against a golden value.
//
//   Ports:
//     clk_i, rst_i      clock, synchronous active-high reset
//     start_i           level start; a run begins on a 0->1 edge seen in IDLE
//     mode_i            0 = LFSR stimulus, 1 = hold the loaded seed as stimulus
//     seed_i            per-lane LFSR seed (lane 0 = bits [WIDTH-1:0])
//     num_vec_i         vectors to issue / responses expected
//     drain_cyc_i       idle-response timeout while draining
//     golden_i          expected signature
//     stim_valid_o/stim_ready_i/stim_data_o   stimulus handshake
//     dut_valid_i/dut_data_i                  response input
//     sig_o, vec_cnt_o, rsp_cnt_o             MISR value and progress counters
//     busy_o, done_o, pass_o, err_o           status (err bit0 timeout, bit1 overflow)
module bist_stream_engine #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      IN_LANES  = 8,
    parameter int unsigned      OUT_LANES = 4,
    parameter int unsigned      CNT_W     = 16,
    parameter logic [WIDTH-1:0] POLY      = 8'hB8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       mode_i,
    input  logic [IN_LANES*WIDTH-1:0]  seed_i,
    input  logic [CNT_W-1:0]           num_vec_i,
    input  logic [7:0]                 drain_cyc_i,
    input  logic [OUT_LANES*WIDTH-1:0] golden_i,
    output logic                       stim_valid_o,
    input  logic                       stim_ready_i,
    output logic [IN_LANES*WIDTH-1:0]  stim_data_o,
    input  logic                       dut_valid_i,
    input  logic [OUT_LANES*WIDTH-1:0] dut_data_i,
    output logic [OUT_LANES*WIDTH-1:0] sig_o,
    output logic [CNT_W-1:0]           vec_cnt_o,
    output logic [CNT_W-1:0]           rsp_cnt_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       pass_o,
    output logic [1:0]                 err_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                       state, state_next;
    logic                         start_d;
    logic [IN_LANES*WIDTH-1:0]    lfsr;
    logic [OUT_LANES*WIDTH-1:0]   sig;
    logic [OUT_LANES*WIDTH-1:0]   golden;
    logic [CNT_W-1:0]             vec_cnt, rsp_cnt, num_vec;
    logic [7:0]                   drain_cyc, idle_cnt;
    logic [1:0]                   err;

    logic launch, xfer, last_xfer, rsp_full, compact, overflow, rsp_done, timeout;

    function automatic logic [WIDTH-1:0] lane_step(input logic [WIDTH-1:0] x);
        return x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        launch       = (state == IDLE) && start_i && !start_d;
        xfer         = (state == RUN) && stim_ready_i;
        last_xfer    = xfer && (vec_cnt + CNT_W'(1) == num_vec);
        rsp_full     = (rsp_cnt == num_vec);
        compact      = ((state == RUN) || (state == DRAIN)) && dut_valid_i && !rsp_full;
        overflow     = ((state == RUN) || (state == DRAIN)) && dut_valid_i && rsp_full;
        // A final response arriving this cycle counts as completion.
        rsp_done     = rsp_full || (compact && (rsp_cnt + CNT_W'(1) == num_vec));
        // Timeout fires on the quiet cycle that brings the idle run length up to
        // drain_cyc; a zero limit times out on the first quiet draining cycle.
        timeout      = (state == DRAIN) && !rsp_done && !dut_valid_i &&
                       ((drain_cyc == 8'd0) || (idle_cnt + 8'd1 == drain_cyc));
        stim_valid_o = (state == RUN);
        busy_o       = (state == RUN) || (state == DRAIN);
        done_o       = (state == DONE);
        pass_o       = (state == DONE) && (sig == golden) && (err == 2'b00) && rsp_full;

        case (state)
            IDLE:    if (launch) state_next = (num_vec_i == '0) ? DRAIN : RUN;
            RUN:     if (last_xfer) state_next = DRAIN;
            DRAIN:   if (rsp_done || timeout) state_next = DONE;
            DONE:    if (!start_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            start_d   <= 1'b0;
            lfsr      <= '0;
            sig       <= '0;
            golden    <= '0;
            vec_cnt   <= '0;
            rsp_cnt   <= '0;
            num_vec   <= '0;
            drain_cyc <= '0;
            idle_cnt  <= '0;
            err       <= '0;
        end else begin
            start_d <= start_i;
            if (launch) begin
                for (int unsigned i = 0; i < IN_LANES; i++) begin
                    // An all-zero lane would lock the LFSR, so it starts at 1.
                    lfsr[i*WIDTH +: WIDTH] <= (seed_i[i*WIDTH +: WIDTH] == '0) ?
                                              WIDTH'(1) : seed_i[i*WIDTH +: WIDTH];
                end
                sig       <= '0;
                vec_cnt   <= '0;
                rsp_cnt   <= '0;
                err       <= '0;
                idle_cnt  <= '0;
                num_vec   <= num_vec_i;
                drain_cyc <= drain_cyc_i;
                golden    <= golden_i;
            end else begin
                if (xfer) begin
                    vec_cnt <= vec_cnt + CNT_W'(1);
                    if (!mode_i) begin
                        for (int unsigned i = 0; i < IN_LANES; i++) begin
                            lfsr[i*WIDTH +: WIDTH] <= lane_step(lfsr[i*WIDTH +: WIDTH]);
                        end
                    end
                end
                if (compact) begin
                    rsp_cnt <= rsp_cnt + CNT_W'(1);
                    for (int unsigned i = 0; i < OUT_LANES; i++) begin
                        sig[i*WIDTH +: WIDTH] <= lane_step(sig[i*WIDTH +: WIDTH]) ^
                                                 dut_data_i[i*WIDTH +: WIDTH];
                    end
                end
                if (overflow) err[1] <= 1'b1;
                if (timeout)  err[0] <= 1'b1;
                if (state == DRAIN) idle_cnt <= dut_valid_i ? 8'd0 : idle_cnt + 8'd1;
            end
        end
    end

    assign stim_data_o = lfsr;
    assign sig_o       = sig;
    assign vec_cnt_o   = vec_cnt;
    assign rsp_cnt_o   = rsp_cnt;
    assign err_o       = err;

endmodule
